vga_scanout: RTL
================

Name: vga_scanout

Overview:
- VGA timing generator and scan-out stage for the 640x480 display.
- Owns the horizontal and vertical pixel counters and drives them as vga_x/vga_y to the renderer.
- Receives the renderer's registered 1-bit pixel back, aligns it with delayed sync and blanking, and drives 12-bit RGB plus hsync/vsync to the pins.
- Also emits a once-per-frame tick that game logic uses to update dino_y, obstacle_x and the other state.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width (cycles)
H_BACK, 48, horizontal back porch (cycles)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
RENDER_LATENCY, 1, cycles from vga_x/vga_y to the matching pixel input (1..4)
FG_RGB, 12'h555, colour when pixel=1
BG_RGB, 12'hFFF, colour when pixel=0

Ports:
pixel_clk  input  1  pixel clock (25.175 MHz nominal); the only clock
rst  input  1  synchronous, active-high reset
pixel  input  1  renderer output; lit=1; corresponds to vga_x/vga_y presented RENDER_LATENCY cycles earlier
vga_x  output  12  current horizontal counter, 0..H_TOTAL-1
vga_y  output  12  current vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
rgb  output  12  {R4,G4,B4} to DAC; 0 during blanking
frame_tick  output  1  one-cycle pulse at start of vertical blanking

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- All counters are 12-bit unsigned. Compare with == against TOTAL-1. Never rely on natural 12-bit overflow.
- Counters:
  - h_cnt increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on the cycle h_cnt wraps, and wraps V_TOTAL-1 -> 0 at that same cycle.
  - vga_x = h_cnt and vga_y = v_cnt, both driven directly from registers.
- Combinational stage-0 flags from the counters:
  - active0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs0 = H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs0 = V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491.
- Alignment pipeline:
  - {active0,hs0,vs0} pass through a RENDER_LATENCY-deep shift register.
  - The stage-L outputs are aligned with the pixel input.
- Output register, updated every pixel_clk edge:
  - hsync <= ~hsL, vsync <= ~vsL.
  - rgb <= activeL ? (pixel ? FG_RGB : BG_RGB) : 12'h000.
  - Net latency from a counter value to the pins is RENDER_LATENCY+1 cycles.
- frame_tick:
  - Registered; high for exactly one cycle.
  - Asserts in the cycle after the counters read (h=0, v=V_ACTIVE).
  - Not delayed by the alignment pipeline.
- Reset (synchronous, takes priority over everything):
  - h_cnt=v_cnt=0, so vga_x=vga_y=0 in the cycle after the reset edge.
  - All shift-register stages cleared to inactive (active=0, hs=0, vs=0).
  - hsync=1, vsync=1, rgb=0, frame_tick=0.
- Reset mid-frame: counters restart at 0,0 on the next edge with no partial-line completion. Pins show blank/inactive-sync until the cleared pipeline drains (RENDER_LATENCY+1 cycles).
- No back-pressure. pixel is sampled unconditionally and ignored outside activeL.
- Line wrap and frame wrap on the same cycle (h=799, v=524): both counters go to 0 on the next edge.

Test Plan:
- Reset: hold rst 3 cycles mid-frame -> next edge vga_x=0, vga_y=0, hsync=1, vsync=1, rgb=0, frame_tick=0. With L=1, pins stay blank 2 cycles after release.
- Line timing: run 2 lines -> hsync low for exactly 96 cycles per line, period 800. Falling edge RENDER_LATENCY+1 cycles after vga_x=656. vga_x sequence 799 -> 0, with vga_y incremented at that edge.
- Frame timing: run 2 full frames -> vsync low exactly 2 lines (1600 cycles) starting with line 490 (+L+1). frame_tick pulses exactly once per 420000 cycles, one cycle after (vga_x=0, vga_y=480).
- Pixel mapping: model renderer as pixel = registered (vga_x[0]^vga_y[0]) -> checkerboard of 12'h555/12'hFFF at pins. First visible pin pixel corresponds to (0,0). rgb=0 at x>=640 or y>=480 regardless of pixel=1.
- Latency sweep: RENDER_LATENCY=3 with a 3-cycle-delayed renderer model -> same pin image and sync edges shifted by 4 cycles relative to counters.
- Wrap corner: force run through (799,524) -> next cycle (0,0). No extra frame_tick; vsync high on line 0.

Source files
------------

// File: rtl/vga_scanout.sv
// VGA 640x480 timing generator and scan-out stage: owns the pixel counters,
// realigns sync/blank with the renderer's delayed pixel, and drives the DAC pins.
module vga_scanout #(
   parameter int          H_ACTIVE       = 640,
   parameter int          H_FRONT        = 16,
   parameter int          H_SYNC         = 96,
   parameter int          H_BACK         = 48,
   parameter int          V_ACTIVE       = 480,
   parameter int          V_FRONT        = 10,
   parameter int          V_SYNC         = 2,
   parameter int          V_BACK         = 33,
   parameter int          RENDER_LATENCY = 1,
   parameter logic [11:0] FG_RGB         = 12'h555,
   parameter logic [11:0] BG_RGB         = 12'hFFF
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic        pixel,
   output logic [11:0] vga_x,
   output logic [11:0] vga_y,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb,
   output logic        frame_tick
);

   localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
   localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);

   function automatic logic [11:0] pixel_colour(input logic lit, input logic active);
      if (!active)
         return 12'h000;
      return lit ? FG_RGB : BG_RGB;
   endfunction

   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic        h_wrap;
   logic        v_wrap;

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         h_cnt <= 12'd0;
         v_cnt <= 12'd0;
      end else begin
         if (h_wrap) begin
            h_cnt <= 12'd0;
            if (v_wrap)
               v_cnt <= 12'd0;
            else
               v_cnt <= v_cnt + 12'd1;
         end else begin
            h_cnt <= h_cnt + 12'd1;
         end
      end
   end

   assign vga_x = h_cnt;
   assign vga_y = v_cnt;

   // Stage 0: timing flags decoded straight from the counters
   logic active_p0;
   logic hs_p0;
   logic vs_p0;

   assign active_p0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_p0     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
   assign vs_p0     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

   // Stages 1..L: flags delayed to line up with the renderer's pixel
   logic active_p [1:RENDER_LATENCY];
   logic hs_p     [1:RENDER_LATENCY];
   logic vs_p     [1:RENDER_LATENCY];

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         for (int i = 1; i <= RENDER_LATENCY; i++) begin
            active_p[i] <= 1'b0;
            hs_p[i]     <= 1'b0;
            vs_p[i]     <= 1'b0;
         end
      end else begin
         active_p[1] <= active_p0;
         hs_p[1]     <= hs_p0;
         vs_p[1]     <= vs_p0;
         for (int i = 2; i <= RENDER_LATENCY; i++) begin
            active_p[i] <= active_p[i-1];
            hs_p[i]     <= hs_p[i-1];
            vs_p[i]     <= vs_p[i-1];
         end
      end
   end

   // Output register: pins lag the counters by RENDER_LATENCY+1 cycles
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         rgb   <= 12'h000;
      end else begin
         hsync <= ~hs_p[RENDER_LATENCY];
         vsync <= ~vs_p[RENDER_LATENCY];
         rgb   <= pixel_colour(pixel, active_p[RENDER_LATENCY]);
      end
   end

   // Frame tick bypasses the alignment pipeline; game logic only needs the cadence
   always_ff @(posedge pixel_clk) begin
      if (rst)
         frame_tick <= 1'b0;
      else
         frame_tick <= (h_cnt == 12'd0) && (v_cnt == V_ACT);
   end

endmodule
